// File: rtl/verifica_fim_jogo_if.sv
// rtl/verifica_fim_jogo_if.sv - scan request, board inputs and result bus of the end-of-game checker
//
// Signals:
//   start          request a scan (driven by the requester)
//   sudokuJogador  committed player board, cell k at bits [CELL_W*k +: CELL_W], MSB first
//   sudokuCompleto solution board, same packing
//   busy           scan in progress
//   done           one-cycle pulse, results valid
//   completo       board fully and correctly filled
//   vazias         number of empty cells
//   erradas        number of filled cells that differ from the solution
// Modports: master = requester side, slave = checker side.
interface verifica_fim_jogo_if #(
  parameter int NUM_CELLS = 81,
  parameter int CELL_W    = 4
);
  logic                          start;
  logic [0:NUM_CELLS*CELL_W-1]   sudokuJogador;
  logic [0:NUM_CELLS*CELL_W-1]   sudokuCompleto;
  logic                          busy;
  logic                          done;
  logic                          completo;
  logic [6:0]                    vazias;
  logic [6:0]                    erradas;

  modport master (
    output start, sudokuJogador, sudokuCompleto,
    input  busy, done, completo, vazias, erradas
  );

  modport slave (
    input  start, sudokuJogador, sudokuCompleto,
    output busy, done, completo, vazias, erradas
  );
endinterface

// File: rtl/verifica_fim_jogo.sv
// rtl/verifica_fim_jogo.sv - scans player board against solution, one cell per clock
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  verifica_fim_jogo_if.slave: start / boards in, busy / done / completo / vazias / erradas out
// A start seen in IDLE snapshots both boards, then NUM_CELLS cells are examined
// (one per edge), then one REPORT edge publishes the counts and pulses done.
module verifica_fim_jogo #(
  parameter int NUM_CELLS = 81,
  parameter int CELL_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  verifica_fim_jogo_if.slave   bus
);

  localparam int BOARD_W = NUM_CELLS * CELL_W;
  localparam int BASE_W  = $clog2(BOARD_W);
  localparam logic [6:0] LAST_IDX = 7'(NUM_CELLS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [0:BOARD_W-1] buf_jog;
  logic [0:BOARD_W-1] buf_sol;
  logic [6:0]         idx;
  logic [6:0]         cnt_vazias;
  logic [6:0]         cnt_erradas;
  logic [BASE_W-1:0]  base;
  logic [CELL_W-1:0]  cell_jog;
  logic [CELL_W-1:0]  cell_sol;
  logic               last_cell;

  // Current cell from the snapshot buffers (ascending range, so +: starts at the cell MSB).
  always_comb begin
    base      = BASE_W'(int'(idx) * CELL_W);
    cell_jog  = buf_jog[base +: CELL_W];
    cell_sol  = buf_sol[base +: CELL_W];
    last_cell = (idx == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SCAN;
      SCAN:    if (last_cell) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy covers every edge from the start edge up to and including the REPORT edge.
  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_jog      <= '0;
      buf_sol      <= '0;
      idx          <= '0;
      cnt_vazias   <= '0;
      cnt_erradas  <= '0;
      bus.done     <= 1'b0;
      bus.completo <= 1'b0;
      bus.vazias   <= '0;
      bus.erradas  <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            buf_jog     <= bus.sudokuJogador;
            buf_sol     <= bus.sudokuCompleto;
            idx         <= '0;
            cnt_vazias  <= '0;
            cnt_erradas <= '0;
          end
        end
        SCAN: begin
          // An empty player cell is never an error, whatever the solution holds.
          if (cell_jog == '0) begin
            cnt_vazias <= cnt_vazias + 7'd1;
          end else if (cell_jog != cell_sol) begin
            cnt_erradas <= cnt_erradas + 7'd1;
          end
          if (!last_cell) begin
            idx <= idx + 7'd1;
          end
        end
        REPORT: begin
          bus.vazias   <= cnt_vazias;
          bus.erradas  <= cnt_erradas;
          bus.completo <= (cnt_vazias == '0) && (cnt_erradas == '0);
          bus.done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_verifica_fim_jogo.sv
// tb/tb_verifica_fim_jogo.sv - directed self-checking bench for verifica_fim_jogo
module tb_verifica_fim_jogo;

  logic clk = 1'b0;
  logic rst = 1'b1;

  verifica_fim_jogo_if bus ();

  verifica_fim_jogo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [0:323] sol;
  logic [0:323] jog;
  int lat;
  int bc;
  int nd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) begin
      passed = passed + 1;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start across one edge (E0); returns 1 time unit after E0.
  task automatic launch();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done after E0. lat = edges after E0 until done seen,
  // bc = cycles with busy high, counting the one after E0. poke > 0 pulses
  // start so that it is sampled at edge E<poke>.
  task automatic wait_done(input int poke, output int lat_o, output int bc_o);
    lat_o = -1;
    bc_o  = bus.busy ? 1 : 0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (n == poke) bus.start = 1'b0;
      if (n == poke - 1) bus.start = 1'b1;
      if (bus.done === 1'b1) begin
        lat_o = n;
        break;
      end
      if (bus.busy === 1'b1) bc_o = bc_o + 1;
    end
  endtask

  task automatic count_done(input int cycles, output int c);
    c = 0;
    for (int n = 0; n < cycles; n++) begin
      tick();
      if (bus.done === 1'b1) c = c + 1;
    end
  endtask

  initial begin
    for (int k = 0; k < 81; k++) begin
      sol[4*k +: 4] = 4'(((k * 7) % 9) + 1);
    end
    bus.start          = 1'b0;
    bus.sudokuJogador  = '0;
    bus.sudokuCompleto = sol;

    // Reset state
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_completo", 32'(bus.completo), 32'd0);
    chk("rst_vazias", 32'(bus.vazias), 32'd0);
    chk("rst_erradas", 32'(bus.erradas), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Perfect board
    bus.sudokuJogador = sol;
    launch();
    chk("t1_busy_e0", 32'(bus.busy), 32'd1);
    wait_done(0, lat, bc);
    chk("t1_latency", 32'(lat), 32'd82);
    chk("t1_busy_cycles", 32'(bc), 32'd82);
    chk("t1_completo", 32'(bus.completo), 32'd1);
    chk("t1_vazias", 32'(bus.vazias), 32'd0);
    chk("t1_erradas", 32'(bus.erradas), 32'd0);
    tick();
    chk("t1_done_cleared", 32'(bus.done), 32'd0);

    // Last cell empty
    jog = sol;
    jog[320:323] = 4'd0;
    bus.sudokuJogador = jog;
    launch();
    chk("t2_completo_held", 32'(bus.completo), 32'd1);
    wait_done(0, lat, bc);
    chk("t2_latency", 32'(lat), 32'd82);
    chk("t2_completo", 32'(bus.completo), 32'd0);
    chk("t2_vazias", 32'(bus.vazias), 32'd1);
    chk("t2_erradas", 32'(bus.erradas), 32'd0);

    // Cell 0 wrong (5 vs 3), cell 40 empty, cell 2 empty with empty solution
    jog = sol;
    jog[0:3] = 4'd5;
    jog[160:163] = 4'd0;
    jog[8:11] = 4'd0;
    bus.sudokuCompleto = sol;
    bus.sudokuCompleto[0:3] = 4'd3;
    bus.sudokuCompleto[8:11] = 4'd0;
    bus.sudokuJogador = jog;
    launch();
    wait_done(0, lat, bc);
    chk("t3_completo", 32'(bus.completo), 32'd0);
    chk("t3_vazias", 32'(bus.vazias), 32'd2);
    chk("t3_erradas", 32'(bus.erradas), 32'd1);
    bus.sudokuCompleto = sol;

    // All-zero player board
    bus.sudokuJogador = '0;
    launch();
    wait_done(0, lat, bc);
    chk("t4_vazias", 32'(bus.vazias), 32'd81);
    chk("t4_erradas", 32'(bus.erradas), 32'd0);
    chk("t4_completo", 32'(bus.completo), 32'd0);

    // Held start retriggers on the edge that clears done
    bus.sudokuJogador = sol;
    bus.start = 1'b1;
    tick();
    wait_done(0, lat, bc);
    chk("t5_first_latency", 32'(lat), 32'd82);
    wait_done(0, lat, bc);
    bus.start = 1'b0;
    chk("t5_retrigger_gap", 32'(lat), 32'd83);
    chk("t5_completo", 32'(bus.completo), 32'd1);
    tick();

    // Snapshot at E0; board change and second start mid-scan are ignored
    bus.sudokuJogador = sol;
    launch();
    bus.sudokuJogador = '0;
    wait_done(10, lat, bc);
    chk("t6_latency", 32'(lat), 32'd82);
    chk("t6_completo", 32'(bus.completo), 32'd1);
    chk("t6_vazias", 32'(bus.vazias), 32'd0);
    count_done(100, nd);
    chk("t6_no_extra_done", 32'(nd), 32'd0);

    // Reset at E40 aborts the scan
    bus.sudokuJogador = '0;
    launch();
    for (int n = 1; n < 40; n++) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t7_busy", 32'(bus.busy), 32'd0);
    chk("t7_done", 32'(bus.done), 32'd0);
    chk("t7_completo", 32'(bus.completo), 32'd0);
    chk("t7_vazias", 32'(bus.vazias), 32'd0);
    chk("t7_erradas", 32'(bus.erradas), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_done(100, nd);
    chk("t7_no_done", 32'(nd), 32'd0);
    jog = sol;
    jog[320:323] = 4'd0;
    bus.sudokuJogador = jog;
    launch();
    wait_done(0, lat, bc);
    chk("t7_fresh_latency", 32'(lat), 32'd82);
    chk("t7_fresh_vazias", 32'(bus.vazias), 32'd1);
    chk("t7_fresh_completo", 32'(bus.completo), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
